// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit with request/ready/rvalid handshake and writeback bundle
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc_plus4,
  input  logic        ex_pc_to_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] alu_result_for_wb,
  output logic [31:0] load_wb_data,
  output logic [4:0]  rd_for_wb,
  output logic        wb_reg_file_in,
  output logic        memtoreg_in,
  output logic        pc_to_reg_in,
  output logic [31:0] pc_plus4_in,
  output logic        mem_wb_flush,
  output logic        mem_stall,
  output logic        misalign_exc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_alu, r_sd, r_pc4, r_rdata;
  logic [4:0]  r_rd;
  logic [2:0]  r_f3;
  logic        r_reg_write, r_mem_read, r_mem_write, r_pc_to_reg;
  logic        w_mem, w_mis, w_start, w_idle, w_done;
  logic [1:0]  w_o;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_load;
  assign w_mem   = ex_valid & (ex_mem_read | ex_mem_write);
  assign w_mis   = w_mem & ((ex_funct3[1:0] == 2'b01 & ex_alu_result[0]) |
                            (ex_funct3[1:0] == 2'b10 & |ex_alu_result[1:0]));
  assign w_idle  = r_state == IDLE;
  assign w_done  = r_state == DONE;
  assign w_start = w_idle & w_mem & !w_mis;
  assign w_o     = r_alu[1:0];
  assign w_b     = r_rdata[{w_o, 3'b000} +: 8];
  assign w_h     = r_rdata[{w_o[1], 4'b0000} +: 16];
  assign w_load  = r_f3 == 3'b000 ? {{24{w_b[7]}}, w_b} :
                   r_f3 == 3'b001 ? {{16{w_h[15]}}, w_h} :
                   r_f3 == 3'b100 ? {24'b0, w_b} :
                   r_f3 == 3'b101 ? {16'b0, w_h} : r_rdata;
  // state register; reset abandons any outstanding transaction
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next-state: stores skip WAIT, rvalid only matters while waiting
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? REQ : IDLE;
      REQ:     w_next = dmem_ready ? (r_mem_read ? WAIT : DONE) : REQ;
      WAIT:    w_next = dmem_rvalid ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // holding register: capture the instruction at detect, load data on response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_alu <= '0; r_sd <= '0; r_pc4 <= '0; r_rdata <= '0; r_rd <= '0; r_f3 <= '0;
      r_reg_write <= 1'b0; r_mem_read <= 1'b0; r_mem_write <= 1'b0; r_pc_to_reg <= 1'b0;
    end else begin
      if (w_start) begin
        r_alu <= ex_alu_result; r_sd <= ex_store_data; r_pc4 <= ex_pc_plus4; r_rd <= ex_rd;
        r_f3 <= ex_funct3; r_reg_write <= ex_reg_write; r_mem_read <= ex_mem_read;
        r_mem_write <= ex_mem_write; r_pc_to_reg <= ex_pc_to_reg;
      end
      if (r_state == WAIT && dmem_rvalid) r_rdata <= dmem_rdata;
    end
  // outputs: pass-through from ex_* in IDLE, latched fields otherwise, all quiet during reset
  always_comb begin
    dmem_req          = r_state == REQ;
    dmem_we           = dmem_req & r_mem_write;
    dmem_addr         = dmem_req ? {r_alu[31:2], 2'b00} : 32'b0;
    dmem_wstrb        = !dmem_req ? 4'b0000 : r_f3[1:0] == 2'b00 ? 4'b0001 << w_o :
                        r_f3[1:0] == 2'b01 ? 4'b0011 << w_o : 4'b1111;
    dmem_wdata        = !dmem_req ? 32'b0 : r_f3[1:0] == 2'b00 ? {4{r_sd[7:0]}} :
                        r_f3[1:0] == 2'b01 ? {2{r_sd[15:0]}} : r_sd;
    alu_result_for_wb = rst ? 32'b0 : w_idle ? ex_alu_result : r_alu;
    rd_for_wb         = rst ? 5'b0 : w_idle ? ex_rd : r_rd;
    pc_plus4_in       = rst ? 32'b0 : w_idle ? ex_pc_plus4 : r_pc4;
    pc_to_reg_in      = !rst & (w_idle ? ex_pc_to_reg : r_pc_to_reg);
    wb_reg_file_in    = !rst & (w_idle ? ex_valid & ex_reg_write & !w_mem : w_done & r_mem_read & r_reg_write);
    memtoreg_in       = !rst & w_done & r_mem_read;
    load_wb_data      = w_done ? w_load : 32'b0;
    mem_stall         = !rst & (w_start | r_state == REQ | r_state == WAIT);
    mem_wb_flush      = rst | (w_idle ? !ex_valid | w_mem : !w_done);
    misalign_exc      = !rst & w_idle & w_mis;
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed checks of pass-through, load/store handshakes, misalignment and reset abort
module tb_mem_stage_lsu;
  logic        clk, rst, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc_to_reg;
  logic [31:0] ex_alu_result, ex_store_data, ex_pc_plus4, dmem_rdata;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        dmem_ready, dmem_rvalid;
  logic        dmem_req, dmem_we, wb_reg_file_in, memtoreg_in, pc_to_reg_in, mem_wb_flush, mem_stall, misalign_exc;
  logic [31:0] dmem_addr, dmem_wdata, alu_result_for_wb, load_wb_data, pc_plus4_in;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  rd_for_wb;
  int total = 0, bad = 0;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_pc_plus4(ex_pc_plus4), .ex_pc_to_reg(ex_pc_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .alu_result_for_wb(alu_result_for_wb), .load_wb_data(load_wb_data), .rd_for_wb(rd_for_wb),
    .wb_reg_file_in(wb_reg_file_in), .memtoreg_in(memtoreg_in), .pc_to_reg_in(pc_to_reg_in),
    .pc_plus4_in(pc_plus4_in), .mem_wb_flush(mem_wb_flush), .mem_stall(mem_stall), .misalign_exc(misalign_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    ex_valid = v; ex_alu_result = a; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
  endtask

  initial begin
    rst = 1'b1; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    ex_pc_plus4 = 32'h44; ex_pc_to_reg = 1'b1;
    set_ex(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010);
    adv; settle;
    chk("rst_alu", alu_result_for_wb, 32'h0);
    chk("rst_wb", {31'b0, wb_reg_file_in}, 32'h0);
    chk("rst_flush", {31'b0, mem_wb_flush}, 32'h1);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rst_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_pc4", pc_plus4_in, 32'h0);
    chk("rst_pcreg", {31'b0, pc_to_reg_in}, 32'h0);
    adv; rst = 1'b0; ex_pc_to_reg = 1'b0;
    set_ex(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    settle;
    chk("add_alu", alu_result_for_wb, 32'h1234);
    chk("add_rd", {27'b0, rd_for_wb}, 32'd5);
    chk("add_wb", {31'b0, wb_reg_file_in}, 32'h1);
    chk("add_stall", {31'b0, mem_stall}, 32'h0);
    chk("add_req", {31'b0, dmem_req}, 32'h0);
    chk("add_flush", {31'b0, mem_wb_flush}, 32'h0);
    chk("add_pc4", pc_plus4_in, 32'h44);
    adv; set_ex(1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000); dmem_rvalid = 1'b1;
    settle;
    chk("bub_flush", {31'b0, mem_wb_flush}, 32'h1);
    chk("bub_wb", {31'b0, wb_reg_file_in}, 32'h0);
    chk("bub_rvalid_stall", {31'b0, mem_stall}, 32'h0);
    adv; dmem_rvalid = 1'b0;
    set_ex(1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
    settle;
    chk("lb_c0_stall", {31'b0, mem_stall}, 32'h1);
    chk("lb_c0_flush", {31'b0, mem_wb_flush}, 32'h1);
    chk("lb_c0_req", {31'b0, dmem_req}, 32'h0);
    chk("lb_c0_wb", {31'b0, wb_reg_file_in}, 32'h0);
    adv; set_ex(1'b0, 32'hDEAD0000, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 3'b111); dmem_ready = 1'b1;
    settle;
    chk("lb_c1_req", {31'b0, dmem_req}, 32'h1);
    chk("lb_c1_addr", dmem_addr, 32'h100);
    chk("lb_c1_we", {31'b0, dmem_we}, 32'h0);
    chk("lb_c1_stall", {31'b0, mem_stall}, 32'h1);
    adv; dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF0011;
    settle;
    chk("lb_c2_req", {31'b0, dmem_req}, 32'h0);
    chk("lb_c2_stall", {31'b0, mem_stall}, 32'h1);
    adv; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    settle;
    chk("lb_c3_stall", {31'b0, mem_stall}, 32'h0);
    chk("lb_c3_flush", {31'b0, mem_wb_flush}, 32'h0);
    chk("lb_c3_data", load_wb_data, 32'hFFFFFF80);
    chk("lb_c3_m2r", {31'b0, memtoreg_in}, 32'h1);
    chk("lb_c3_wb", {31'b0, wb_reg_file_in}, 32'h1);
    chk("lb_c3_rd", {27'b0, rd_for_wb}, 32'd7);
    chk("lb_c3_alu", alu_result_for_wb, 32'h103);
    adv;
    settle;
    chk("lb_c4_m2r", {31'b0, memtoreg_in}, 32'h0);
    chk("lb_c4_data", load_wb_data, 32'h0);
    adv; set_ex(1'b1, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b101);
    settle;
    chk("lhu_c0_stall", {31'b0, mem_stall}, 32'h1);
    adv; set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    settle;
    chk("lhu_c1_req", {31'b0, dmem_req}, 32'h1);
    chk("lhu_c1_addr", dmem_addr, 32'h100);
    chk("lhu_c1_stall", {31'b0, mem_stall}, 32'h1);
    adv; dmem_rvalid = 1'b0;
    settle;
    chk("lhu_c2_req", {31'b0, dmem_req}, 32'h1);
    chk("lhu_c2_stall", {31'b0, mem_stall}, 32'h1);
    adv; dmem_ready = 1'b1;
    settle;
    chk("lhu_c3_req", {31'b0, dmem_req}, 32'h1);
    chk("lhu_c3_stall", {31'b0, mem_stall}, 32'h1);
    adv; dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF0000;
    settle;
    chk("lhu_c4_req", {31'b0, dmem_req}, 32'h0);
    chk("lhu_c4_stall", {31'b0, mem_stall}, 32'h1);
    adv; dmem_rvalid = 1'b0;
    settle;
    chk("lhu_c5_stall", {31'b0, mem_stall}, 32'h0);
    chk("lhu_c5_data", load_wb_data, 32'h0000BEEF);
    chk("lhu_c5_rd", {27'b0, rd_for_wb}, 32'd9);
    adv; set_ex(1'b1, 32'h201, 32'h123456AB, 5'd4, 1'b1, 1'b0, 1'b1, 3'b000);
    settle;
    chk("sb_c0_stall", {31'b0, mem_stall}, 32'h1);
    adv; set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000); dmem_ready = 1'b1;
    settle;
    chk("sb_c1_req", {31'b0, dmem_req}, 32'h1);
    chk("sb_c1_we", {31'b0, dmem_we}, 32'h1);
    chk("sb_c1_addr", dmem_addr, 32'h200);
    chk("sb_c1_wstrb", {28'b0, dmem_wstrb}, 32'b0010);
    chk("sb_c1_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_c1_stall", {31'b0, mem_stall}, 32'h1);
    adv; dmem_ready = 1'b0;
    settle;
    chk("sb_c2_stall", {31'b0, mem_stall}, 32'h0);
    chk("sb_c2_flush", {31'b0, mem_wb_flush}, 32'h0);
    chk("sb_c2_wb", {31'b0, wb_reg_file_in}, 32'h0);
    chk("sb_c2_m2r", {31'b0, memtoreg_in}, 32'h0);
    adv; set_ex(1'b1, 32'h202, 32'h0000CAFE, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
    adv; set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000); dmem_ready = 1'b1;
    settle;
    chk("sh_wstrb", {28'b0, dmem_wstrb}, 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'hCAFECAFE);
    adv; dmem_ready = 1'b0;
    adv; set_ex(1'b1, 32'h302, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010);
    settle;
    chk("mis_exc", {31'b0, misalign_exc}, 32'h1);
    chk("mis_req", {31'b0, dmem_req}, 32'h0);
    chk("mis_flush", {31'b0, mem_wb_flush}, 32'h1);
    chk("mis_stall", {31'b0, mem_stall}, 32'h0);
    chk("mis_wb", {31'b0, wb_reg_file_in}, 32'h0);
    adv; set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    settle;
    chk("mis_next_exc", {31'b0, misalign_exc}, 32'h0);
    chk("mis_next_req", {31'b0, dmem_req}, 32'h0);
    adv; set_ex(1'b1, 32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010);
    adv; set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000); dmem_ready = 1'b1;
    adv; dmem_ready = 1'b0;
    settle;
    chk("rw_wait_stall", {31'b0, mem_stall}, 32'h1);
    adv; rst = 1'b1;
    #1;
    chk("rw_rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rw_rst_flush", {31'b0, mem_wb_flush}, 32'h1);
    chk("rw_rst_req", {31'b0, dmem_req}, 32'h0);
    adv; rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h55667788;
    settle;
    chk("rw_late_stall", {31'b0, mem_stall}, 32'h0);
    chk("rw_late_m2r", {31'b0, memtoreg_in}, 32'h0);
    adv; dmem_rvalid = 1'b0;
    settle;
    chk("rw_after_m2r", {31'b0, memtoreg_in}, 32'h0);
    chk("rw_after_wb", {31'b0, wb_reg_file_in}, 32'h0);
    chk("rw_after_data", load_wb_data, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It runs data-memory transactions over a request/ready/rvalid handshake and stalls the front of the pipeline while a transaction is outstanding. It also produces the writeback bundle (ALU result, formatted load data, rd, write enable, memtoreg, pc+4, pc_to_reg) that the MEM/WB register captures.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX/MEM slot holds a real instruction
- ex_alu_result  in  32  ALU result / effective address
- ex_store_data  in  32  rs2 value for stores
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- ex_mem_read / ex_mem_write  in  1 each  load / store
- ex_funct3  in  3  access size/sign
- ex_pc_plus4  in  32; ex_pc_to_reg  in  1  JAL/JALR link path
- dmem_req  out  1  request valid
- dmem_we  out  1  1=store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32; dmem_wstrb  out  4  byte lanes
- dmem_ready  in  1  request accepted this cycle
- dmem_rvalid  in  1; dmem_rdata  in  32  load response
- alu_result_for_wb, load_wb_data  out  32 each
- rd_for_wb  out  5; wb_reg_file_in, memtoreg_in, pc_to_reg_in  out  1 each; pc_plus4_in  out  32
- mem_wb_flush  out  1  insert bubble into MEM/WB (MEM/WB en tied high)
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- misalign_exc  out  1  one-cycle misaligned-access pulse

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. A holding register latches all ex_* fields plus rdata.
- IDLE, no memory op: pass-through. Writeback outputs come combinationally from ex_*. wb_reg_file_in = ex_valid & ex_reg_write. memtoreg_in=0, load_wb_data=0. mem_stall=0. mem_wb_flush = !ex_valid.
- IDLE, ex_valid & (mem_read|mem_write), aligned: latch fields and go to REQ. mem_stall=1, mem_wb_flush=1.
- Alignment rule: funct3[1:0]=01 requires addr[0]=0. funct3[1:0]=10 requires addr[1:0]=0. Bytes are always aligned.
- Misaligned access: no request is issued. misalign_exc=1 for that cycle. The instruction becomes a bubble (mem_wb_flush=1, wb_reg_file_in=0). No stall; stay in IDLE.
- REQ: dmem_req=1 with the latched addr/we/wdata/wstrb, held stable until dmem_ready. On ready, a store goes to DONE and a load goes to WAIT.
- WAIT: dmem_req=0. On dmem_rvalid, capture dmem_rdata and go to DONE. mem_stall=1 and mem_wb_flush=1 throughout REQ and WAIT.
- DONE: mem_stall=0, mem_wb_flush=0. Outputs come from the latched fields. memtoreg_in=1 for loads, 0 for stores. wb_reg_file_in=latched reg_write for loads, 0 for stores. Go to IDLE next cycle.
- Store lanes, with o=addr[1:0]:
  - SB: wstrb=4'b0001<<o, wdata={4{data[7:0]}}.
  - SH: wstrb=4'b0011<<o, wdata={2{data[15:0]}}.
  - SW: wstrb=4'b1111, wdata=data.
- Load formatting: select a byte/halfword from rdata by o.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - funct3 values 011/110/111 are treated as LW.
- dmem_rvalid outside WAIT is ignored.

## Timing
- Reset (and while rst is high): state=IDLE, holding register=0. All outputs are 0 except mem_wb_flush=1.
- Reset mid-transaction abandons it. A late rvalid arriving after reset is ignored.
- dmem_rvalid arrives no earlier than the cycle after dmem_ready.
- Load, zero-wait memory: detect (c0), REQ+ready (c1), WAIT+rvalid (c2), DONE (c3). mem_stall is high c0–c2. The MEM/WB register captures the load at the end of c3.
- Store, zero-wait memory: c0 detect, c1 REQ+ready, c2 DONE. Stall c0–c1.
- Each extra cycle of ready or rvalid latency adds exactly one stall cycle.
- Pass-through instructions add zero latency.
- ex_* may change once mem_stall falls; the block uses only latched values after c0.

## Test plan
- ALU op add, ex_rd=5, alu=0x0000_1234, reg_write=1 -> same cycle: alu_result_for_wb=0x1234, rd_for_wb=5, wb_reg_file_in=1, mem_stall=0, dmem_req=0.
- LB addr 0x103, rdata=0x80FF_0011, ready immediate, rvalid next cycle -> dmem_addr=0x100; stall for 3 cycles; DONE: load_wb_data=0xFFFF_FF80, memtoreg_in=1.
- LHU addr 0x102, rdata=0xBEEF_0000, ready delayed 2 cycles -> 5 stall cycles; load_wb_data=0x0000_BEEF.
- SB addr 0x201, data=0xAB -> dmem_wstrb=0010, dmem_wdata=0xABAB_ABAB, dmem_we=1; DONE with wb_reg_file_in=0; 2 stall cycles.
- LW addr 0x302 -> misalign_exc=1 for one cycle, dmem_req never asserted, mem_wb_flush=1, mem_stall=0.
- rst asserted during WAIT, then rvalid pulses after release -> state IDLE, no DONE writeback, mem_stall=0 immediately.
